mac_act_buffer: RTL and testbench

- Downstream stage of `mac`. Captures `mac_out` on each `done` pulse and adds a per-neuron bias with saturation.
- Optionally applies ReLU, then queues the result with a neuron index in a small FIFO.
- The next layer or the output writer drains the FIFO over a valid/ready handshake.
- All data is signed Q8.8 two's complement (0x0100 = 1.0).

---
 rtl/nn_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/mac_act_buffer.sv | 126 ++++++++++++
 tb/tb_mac_act_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the neural-network datapath blocks.
//   - DATA_W and the Q8.8 constants (signed, 0x0100 = 1.0)
//   - sat_add(): signed Q8.8 addition clamped to [Q_MIN, Q_MAX], used by mac
package nn_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] q88_t;

    localparam q88_t Q_ONE = 16'h0100;
    localparam q88_t Q_MAX = 16'h7FFF;
    localparam q88_t Q_MIN = 16'h8000;

    // Sign-extend both operands by one bit; a carry into the extra bit that
    // disagrees with the top data bit means the true sum left the Q8.8 range.
    function automatic q88_t sat_add(input q88_t a, input q88_t b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) begin
            return s[DATA_W] ? Q_MIN : Q_MAX;
        end else begin
            return s[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy counter.
//   clk, reset (sync, active-low)
//   push/push_data : write request; accepted when not full, or when full and
//                    a pop is accepted in the same cycle
//   pop            : read request; ignored while empty
//   pop_data       : head entry (zero while empty)
//   full/empty     : count == DEPTH / count == 0
//   count          : occupancy 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rptr_q];

    // A pop frees the head slot this cycle, so a full FIFO can still take a push.
    assign pop_en   = pop && !empty;
    assign push_en  = push && (!full || pop_en);

    // Next-state for storage, pointers (wrap naturally, DEPTH is a power of 2) and count.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_en) begin
            mem_d[wptr_q] = push_data;
            wptr_d        = wptr_q + PTR_W'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_en) begin
            rptr_d = rptr_q + PTR_W'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mac_act_buffer.sv
// mac_act_buffer: bias-add / saturate / optional ReLU on each mac result,
// then queue {value, neuron index} for the next layer.
//   clk, reset (sync, active-low)
//   done, mac_out, bias_in       : one result per done pulse
//   act_out, act_idx, act_valid  : FIFO head, valid/ready handshake with act_ready
//   layer_done                   : pulse after the entry for neuron NUM_NEURONS-1 pops
//   overflow                     : sticky, a result was dropped on a full FIFO
//   count                        : FIFO occupancy
module mac_act_buffer #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4,
    parameter int NUM_NEURONS = 8,
    parameter int IDX_W       = 3,
    parameter bit RELU_EN     = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   done,
    input  logic [DATA_W-1:0]      mac_out,
    input  logic [DATA_W-1:0]      bias_in,
    output logic [DATA_W-1:0]      act_out,
    output logic [IDX_W-1:0]       act_idx,
    output logic                   act_valid,
    input  logic                   act_ready,
    output logic                   layer_done,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count
);

    import nn_pkg::*;

    localparam int             ENTRY_W = DATA_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] sat_val;
    logic [DATA_W-1:0] act_val;

    logic              stg_valid_q, stg_valid_d;
    logic [DATA_W-1:0] stg_data_q,  stg_data_d;
    logic [IDX_W-1:0]  stg_idx_q,   stg_idx_d;
    logic [IDX_W-1:0]  widx_q,      widx_d;
    logic              overflow_q,  overflow_d;
    logic              layer_done_q, layer_done_d;

    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    // Stage-1 arithmetic: widened add, clamp to the signed range, then ReLU.
    always_comb begin
        sum = {mac_out[DATA_W-1], mac_out} + {bias_in[DATA_W-1], bias_in};
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            sat_val = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sat_val = sum[DATA_W-1:0];
        end
        if (RELU_EN && sat_val[DATA_W-1]) begin
            act_val = '0;
        end else begin
            act_val = sat_val;
        end
    end

    assign act_valid = !fifo_empty;
    assign pop       = act_valid && act_ready;
    assign act_out   = head[ENTRY_W-1:IDX_W];
    assign act_idx   = head[IDX_W-1:0];

    // Next-state for the stage register, write index and status flags.
    always_comb begin
        stg_valid_d = done;
        stg_data_d  = stg_data_q;
        stg_idx_d   = stg_idx_q;
        widx_d      = widx_q;
        if (done) begin
            stg_data_d = act_val;
            stg_idx_d  = widx_q;
            widx_d     = (widx_q == LAST_IDX) ? '0 : widx_q + IDX_W'(1);
        end else begin
            widx_d = widx_q;
        end
        // The stage result is lost only when full and no pop makes room.
        overflow_d   = overflow_q | (stg_valid_q & fifo_full & ~pop);
        layer_done_d = pop && (act_idx == LAST_IDX);
    end

    // Pipeline and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stg_valid_q  <= 1'b0;
            stg_data_q   <= '0;
            stg_idx_q    <= '0;
            widx_q       <= '0;
            overflow_q   <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            stg_valid_q  <= stg_valid_d;
            stg_data_q   <= stg_data_d;
            stg_idx_q    <= stg_idx_d;
            widx_q       <= widx_d;
            overflow_q   <= overflow_d;
            layer_done_q <= layer_done_d;
        end
    end

    assign overflow   = overflow_q;
    assign layer_done = layer_done_q;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (stg_valid_q),
        .push_data ({stg_data_q, stg_idx_q}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

endmodule

// File: tb/tb_mac_act_buffer.sv
module tb_mac_act_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        done;
    logic [15:0] mac_out;
    logic [15:0] bias_in;
    logic        act_ready;

    logic [15:0] r_act_out, p_act_out;
    logic [2:0]  r_act_idx, p_act_idx;
    logic        r_act_valid, p_act_valid;
    logic        r_layer_done, p_layer_done;
    logic        r_overflow, p_overflow;
    logic [2:0]  r_count, p_count;

    always #5 clk = ~clk;

    mac_act_buffer #(.DATA_W(16), .DEPTH(4), .NUM_NEURONS(8), .IDX_W(3), .RELU_EN(1'b1)) dut_r (
        .clk(clk), .reset(reset), .done(done), .mac_out(mac_out), .bias_in(bias_in),
        .act_out(r_act_out), .act_idx(r_act_idx), .act_valid(r_act_valid), .act_ready(act_ready),
        .layer_done(r_layer_done), .overflow(r_overflow), .count(r_count));

    mac_act_buffer #(.DATA_W(16), .DEPTH(4), .NUM_NEURONS(8), .IDX_W(3), .RELU_EN(1'b0)) dut_p (
        .clk(clk), .reset(reset), .done(done), .mac_out(mac_out), .bias_in(bias_in),
        .act_out(p_act_out), .act_idx(p_act_idx), .act_valid(p_act_valid), .act_ready(act_ready),
        .layer_done(p_layer_done), .overflow(p_overflow), .count(p_count));

    // Reference model: a queue of results plus the one-deep stage in front of it.
    typedef struct { logic [15:0] v_relu; logic [15:0] v_pass; logic [2:0] idx; } ent_t;
    ent_t mq[$];
    bit   m_stg;
    ent_t m_stg_e;
    int   m_widx;
    bit   m_ovf;
    bit   m_ld;

    int checks = 0;
    int errors = 0;
    int ld_cnt = 0;
    logic [2:0] pops[$];

    typedef struct { logic [15:0] mac; logic [15:0] bias; logic [15:0] exp_r; logic [15:0] exp_p; } vec_t;
    vec_t vt[7];

    function automatic logic [15:0] ref_act(logic [15:0] a, logic [15:0] b, bit relu);
        int sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        s  = sa + sb;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: update the model with the inputs the DUT sees at this
    // edge, then compare all outputs on the following falling edge.
    task automatic tick();
        ent_t e;
        bit   pop;
        if (reset && r_act_valid && act_ready) pops.push_back(r_act_idx);
        if (!reset) begin
            mq.delete();
            m_stg = 0; m_widx = 0; m_ovf = 0; m_ld = 0;
        end else begin
            pop  = (mq.size() > 0) && act_ready;
            m_ld = 0;
            if (pop) begin
                e = mq.pop_front();
                if (e.idx == 3'd7) m_ld = 1;
            end
            if (m_stg) begin
                if (mq.size() < 4) mq.push_back(m_stg_e);
                else m_ovf = 1;
            end
            m_stg = done;
            if (done) begin
                m_stg_e.v_relu = ref_act(mac_out, bias_in, 1'b1);
                m_stg_e.v_pass = ref_act(mac_out, bias_in, 1'b0);
                m_stg_e.idx    = 3'(m_widx);
                m_widx         = (m_widx + 1) % 8;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (r_layer_done) ld_cnt++;
        chk("r_valid", 32'(r_act_valid), 32'(mq.size() != 0));
        chk("p_valid", 32'(p_act_valid), 32'(mq.size() != 0));
        chk("r_count", 32'(r_count), 32'(mq.size()));
        chk("p_count", 32'(p_count), 32'(mq.size()));
        chk("r_overflow", 32'(r_overflow), 32'(m_ovf));
        chk("p_overflow", 32'(p_overflow), 32'(m_ovf));
        chk("r_layer_done", 32'(r_layer_done), 32'(m_ld));
        chk("p_layer_done", 32'(p_layer_done), 32'(m_ld));
        if (mq.size() != 0) begin
            chk("r_act_out", 32'(r_act_out), 32'(mq[0].v_relu));
            chk("p_act_out", 32'(p_act_out), 32'(mq[0].v_pass));
            chk("r_act_idx", 32'(r_act_idx), 32'(mq[0].idx));
            chk("p_act_idx", 32'(p_act_idx), 32'(mq[0].idx));
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            done    = 1'b1;
            mac_out = 16'($urandom);
            bias_in = 16'($urandom);
            tick();
        end
        reset = 1'b1;
        done  = 1'b0;
    endtask

    task automatic check_pops(string name, int n, int first);
        chk({name, "_npop"}, 32'(pops.size()), 32'(n));
        for (int i = 0; i < n && i < pops.size(); i++) begin
            chk({name, "_idx"}, 32'(pops[i]), 32'((first + i) % 8));
        end
    endtask

    initial begin
        vt[0] = '{16'h0100, 16'h0080, 16'h0180, 16'h0180};
        vt[1] = '{16'h7F00, 16'h0200, 16'h7FFF, 16'h7FFF};
        vt[2] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
        vt[3] = '{16'h8000, 16'hFF00, 16'h0000, 16'h8000};
        vt[4] = '{16'h8000, 16'h8000, 16'h0000, 16'h8000};
        vt[5] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vt[6] = '{16'h0005, 16'hFFF0, 16'h0000, 16'hFFF5};

        reset = 1'b0; done = 1'b0; mac_out = '0; bias_in = '0; act_ready = 1'b0;

        // Reset with done pulsing, then idle: nothing may appear.
        do_reset();
        chk("rst_act_out", 32'(r_act_out), 32'h0);
        chk("rst_act_idx", 32'(r_act_idx), 32'h0);
        chk("rst_count", 32'(r_count), 32'h0);
        for (int i = 0; i < 3; i++) tick();
        chk("post_rst_valid", 32'(r_act_valid), 32'h0);

        // Table vectors: bias/saturate/ReLU values and the two-cycle latency.
        act_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            mac_out = vt[i].mac; bias_in = vt[i].bias; done = 1'b1;
            tick();
            chk("lat_not_yet", 32'(r_act_valid), 32'h0);
            done = 1'b0;
            tick();
            chk("vec_valid", 32'(r_act_valid), 32'h1);
            chk("vec_relu", 32'(r_act_out), 32'(vt[i].exp_r));
            chk("vec_pass", 32'(p_act_out), 32'(vt[i].exp_p));
            chk("vec_idx", 32'(r_act_idx), 32'(i));
            tick();
            chk("vec_popped", 32'(r_act_valid), 32'h0);
        end

        // Five back-to-back results into a 4-deep FIFO with no consumer.
        do_reset();
        act_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            done = 1'b1; mac_out = 16'($urandom); bias_in = 16'($urandom_range(0, 255));
            tick();
        end
        done = 1'b0;
        tick(); tick();
        chk("ovf_count", 32'(r_count), 32'h4);
        chk("ovf_flag", 32'(r_overflow), 32'h1);
        pops.delete();
        act_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_pops("ovf", 4, 0);
        chk("ovf_sticky", 32'(r_overflow), 32'h1);

        // Full FIFO, stage-2 push coincides with a pop: accepted.
        do_reset();
        act_ready = 1'b0;
        pops.delete();
        for (int i = 0; i < 5; i++) begin
            done = 1'b1; mac_out = 16'($urandom); bias_in = 16'($urandom);
            tick();
        end
        done = 1'b0; act_ready = 1'b1;
        tick();
        act_ready = 1'b0;
        chk("fullpop_count", 32'(r_count), 32'h4);
        chk("fullpop_ovf", 32'(r_overflow), 32'h0);
        act_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_pops("fullpop", 5, 0);

        // Stream nine results with a toggling consumer.
        do_reset();
        pops.delete();
        ld_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            done      = (c % 2 == 0) && (c < 18);
            act_ready = c[0];
            mac_out   = 16'($urandom);
            bias_in   = 16'($urandom);
            tick();
        end
        done = 1'b0;
        check_pops("stream", 9, 0);
        chk("stream_ld_once", 32'(ld_cnt), 32'h1);
        chk("stream_ovf", 32'(r_overflow), 32'h0);

        // Random traffic with occasional reset, checked against the model each cycle.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 99) != 0);
            done      = ($urandom_range(0, 99) < 60);
            act_ready = ($urandom_range(0, 99) < 45);
            mac_out   = 16'($urandom);
            bias_in   = 16'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
